// File: rtl/match_sequencer_if.sv
// Bus between the match sequencer and the game core: tick/start/lives/requests
// in, play control, grants and scoreboard out.
interface match_sequencer_if;
  logic       tick;
  logic       start;
  logic [1:0] lives1;
  logic [1:0] lives2;
  logic       act_req1;
  logic       act_req2;
  logic       play_en;
  logic       round_rst;
  logic       grant1;
  logic       grant2;
  logic [1:0] wins1;
  logic [1:0] wins2;
  logic [1:0] round_num;
  logic [1:0] winner;
  logic [2:0] fsm_state;

  modport master (
    output tick, start, lives1, lives2, act_req1, act_req2,
    input  play_en, round_rst, grant1, grant2, wins1, wins2, round_num, winner, fsm_state
  );
  modport slave (
    input  tick, start, lives1, lives2, act_req1, act_req2,
    output play_en, round_rst, grant1, grant2, wins1, wins2, round_num, winner, fsm_state
  );
endinterface

// File: rtl/match_sequencer.sv
// Two-player match sequencer: countdown, fight with round-robin action grants,
// round/match scoring. Optional round timer under `SUDDEN_DEATH_EN.
module match_sequencer #(
  parameter int COUNT_TICKS   = 3,
  parameter int ROUNDS_TO_WIN = 2,
  parameter int ROUND_TICKS   = 60
) (
  input logic              clk,
  input logic              reset,
  match_sequencer_if.slave bus
);
  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_CLEAR     = 3'd1;
  localparam logic [2:0] ST_COUNTDOWN = 3'd2;
  localparam logic [2:0] ST_FIGHT     = 3'd3;
  localparam logic [2:0] ST_ROUND_END = 3'd4;
  localparam logic [2:0] ST_MATCH_END = 3'd5;
  localparam logic [1:0] RTW          = ROUNDS_TO_WIN[1:0];

  logic [2:0] state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [1:0] w1_q, w1_d, w2_q, w2_d, rnd_q, rnd_d, win_q, win_d;
  logic       ptr_q, ptr_d;     // 0: player 1 wins a tie, 1: player 2
  logic       armed_q, armed_d; // start seen low while in MATCH_END
  logic       g1_q, g1_d, g2_q, g2_d;
  logic       new_match, l1z, l2z, expire;

  function automatic logic [1:0] sat_inc(input logic [1:0] v);
    return (v == 2'd3) ? v : v + 2'd1;
  endfunction

  assign l1z = (bus.lives1 == 2'd0);
  assign l2z = (bus.lives2 == 2'd0);

`ifdef SUDDEN_DEATH_EN
  logic [7:0] timer_q, timer_d;
  assign expire = (timer_q == 8'd1);
`else
  // No round timer: ROUND_TICKS is never 0 in range, so expiry never fires.
  assign expire = (ROUND_TICKS == 0);
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    w1_d      = w1_q;
    w2_d      = w2_q;
    rnd_d     = rnd_q;
    win_d     = win_q;
    ptr_d     = ptr_q;
    armed_d   = armed_q;
    g1_d      = 1'b0;
    g2_d      = 1'b0;
    new_match = 1'b0;
`ifdef SUDDEN_DEATH_EN
    timer_d   = timer_q;
`endif
    case (state_q)
      ST_IDLE: if (bus.start) new_match = 1'b1;
      ST_CLEAR: begin
        state_d = ST_COUNTDOWN;
        cnt_d   = COUNT_TICKS[3:0];
      end
      ST_COUNTDOWN: if (bus.tick) begin
        if (cnt_q <= 4'd1) begin
          state_d = ST_FIGHT;
          cnt_d   = 4'd0;
`ifdef SUDDEN_DEATH_EN
          timer_d = ROUND_TICKS[7:0];
`endif
        end else cnt_d = cnt_q - 4'd1;
      end
      ST_FIGHT: if (bus.tick) begin
`ifdef SUDDEN_DEATH_EN
        timer_d = timer_q - 8'd1;
`endif
        if (l1z || l2z || expire) begin
          state_d = ST_ROUND_END;
          if (l1z && !l2z) w2_d = sat_inc(w2_q);
          else if (l2z && !l1z) w1_d = sat_inc(w1_q);
          else if (!l1z && !l2z) begin
            // timer expiry: more lives wins, equal lives is a draw
            if (bus.lives1 > bus.lives2) w1_d = sat_inc(w1_q);
            else if (bus.lives2 > bus.lives1) w2_d = sat_inc(w2_q);
          end
        end else if (bus.act_req1 && bus.act_req2) begin
          g1_d  = ~ptr_q;
          g2_d  = ptr_q;
          ptr_d = ~ptr_q;
        end else begin
          g1_d = bus.act_req1;
          g2_d = bus.act_req2;
        end
      end
      ST_ROUND_END: begin
        if (w1_q == RTW || w2_q == RTW) begin
          state_d = ST_MATCH_END;
          win_d   = (w1_q == RTW) ? 2'b01 : 2'b10;
          armed_d = 1'b0;
        end else begin
          state_d = ST_CLEAR;
          rnd_d   = sat_inc(rnd_q);
        end
      end
      ST_MATCH_END: begin
        if (!bus.start) armed_d = 1'b1;
        else if (armed_q) new_match = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
    if (new_match) begin
      state_d = ST_CLEAR;
      w1_d    = 2'd0;
      w2_d    = 2'd0;
      win_d   = 2'b00;
      rnd_d   = 2'd1;
      armed_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      w1_q    <= 2'd0;
      w2_q    <= 2'd0;
      rnd_q   <= 2'd0;
      win_q   <= 2'b00;
      ptr_q   <= 1'b0;
      armed_q <= 1'b0;
      g1_q    <= 1'b0;
      g2_q    <= 1'b0;
`ifdef SUDDEN_DEATH_EN
      timer_q <= 8'd0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      w1_q    <= w1_d;
      w2_q    <= w2_d;
      rnd_q   <= rnd_d;
      win_q   <= win_d;
      ptr_q   <= ptr_d;
      armed_q <= armed_d;
      g1_q    <= g1_d;
      g2_q    <= g2_d;
`ifdef SUDDEN_DEATH_EN
      timer_q <= timer_d;
`endif
    end
  end

  assign bus.play_en   = (state_q == ST_FIGHT);
  assign bus.round_rst = (state_q == ST_CLEAR);
  assign bus.grant1    = g1_q;
  assign bus.grant2    = g2_q;
  assign bus.wins1     = w1_q;
  assign bus.wins2     = w2_q;
  assign bus.round_num = rnd_q;
  assign bus.winner    = win_q;
  assign bus.fsm_state = state_q;
endmodule

// File: doc/match_sequencer.md
MATCH_SEQUENCER -- requirements
Module: match_sequencer

Interface
REQ-001 The block SHALL have parameter COUNT_TICKS, default 3; it sets the number of game ticks in the pre-round countdown (range 1..15).
REQ-002 The block SHALL have parameter ROUNDS_TO_WIN, default 2; it sets the round wins needed to take the match (range 1..3).
REQ-003 The block SHALL have parameter ROUND_TICKS, default 60; it sets the round time limit in ticks and is used only under SUDDEN_DEATH_EN (range 1..255).
REQ-004 Port clk SHALL be an input, 1 bit: the single system clock, rising edge.
REQ-005 Port reset SHALL be an input, 1 bit: asynchronous, active-low reset.
REQ-006 Port tick SHALL be an input, 1 bit: one-cycle game-tick strobe from the clock divider.
REQ-007 Port start SHALL be an input, 1 bit, level: request to begin a match.
REQ-008 Ports lives1 and lives2 SHALL be inputs, 2 bits each: current lives of player 1 and player 2.
REQ-009 Ports act_req1 and act_req2 SHALL be inputs, 1 bit each, level: player action pending.
REQ-010 Port play_en SHALL be an output, 1 bit: player update enable.
REQ-011 Port round_rst SHALL be an output, 1 bit: one-cycle pulse that reinitialises both player modules.
REQ-012 Ports grant1 and grant2 SHALL be outputs, 1 bit each: one-cycle action-slot grants.
REQ-013 Ports wins1 and wins2 SHALL be outputs, 2 bits each: rounds won by each player.
REQ-014 Port round_num SHALL be an output, 2 bits: current round number, saturating at 3.
REQ-015 Port winner SHALL be an output, 2 bits: 00 none, 01 player 1, 10 player 2.
REQ-016 Port fsm_state SHALL be an output, 3 bits: current state encoding.

Function
REQ-017 States SHALL be encoded IDLE=0, CLEAR=1, COUNTDOWN=2, FIGHT=3, ROUND_END=4, MATCH_END=5; codes 6 and 7 SHALL return to IDLE on the next clock.
REQ-018 IDLE->CLEAR SHALL occur on the clock where start=1; entering CLEAR from IDLE SHALL clear wins1, wins2 and winner, and set round_num to 1.
REQ-019 CLEAR SHALL last exactly one clock with round_rst=1, then go to COUNTDOWN with the countdown counter loaded with COUNT_TICKS.
REQ-020 COUNTDOWN SHALL decrement on each tick; on the tick where the counter equals 1 it SHALL go to FIGHT; ticks are the only events that advance it.
REQ-021 play_en SHALL be 1 only in FIGHT; all other states SHALL hold play_en=0.
REQ-022 In FIGHT, on a tick cycle, grants SHALL be registered: the grant appears the clock after the tick, lasts one clock, and grant1 and grant2 are never both 1.
REQ-023 Single request at a tick SHALL be granted to its requester and SHALL leave the priority pointer unchanged.
REQ-024 Both requests at a tick SHALL be granted to the player named by the priority pointer, after which the pointer SHALL toggle; the pointer SHALL reset to player 1.
REQ-025 Requests outside FIGHT or without tick SHALL be ignored; no request is queued.
REQ-026 In FIGHT, at a tick, lives1==0 XOR lives2==0 SHALL go to ROUND_END and increment the surviving player's wins, saturating at 3; no grant is issued on that tick.
REQ-027 In FIGHT, at a tick, both lives==0 SHALL be a draw: the state goes to ROUND_END with wins unchanged.
REQ-028 ROUND_END SHALL last one clock; if either wins count equals ROUNDS_TO_WIN the state goes to MATCH_END with winner set, else it goes to CLEAR with round_num incremented (saturating).
REQ-029 MATCH_END SHALL hold all counters and winner until start is sampled 0 then 1 (a rising edge), then go to CLEAR with the same effect as REQ-018.
REQ-030 start held high through MATCH_END SHALL NOT restart the match.

Reset
REQ-031 reset=0 SHALL immediately force IDLE, play_en=0, round_rst=0, grant1=grant2=0, wins1=wins2=0, round_num=0, winner=00, priority pointer=player 1, and all counters to 0, independent of clk.
REQ-032 Release of reset SHALL take effect on the first clk edge with reset=1; reset mid-match SHALL discard all match progress.

Configuration
REQ-033 Macro SUDDEN_DEATH_EN defined SHALL add a round timer: loaded with ROUND_TICKS on entry to FIGHT, decremented per tick, and at expiry (no life at 0) the player with more lives wins the round and equal lives is a draw (REQ-027 path).
REQ-034 Macro SUDDEN_DEATH_EN undefined SHALL mean no timer exists and rounds end only by lives reaching 0.

Verification
REQ-035 Verification SHALL cover: reset=0 mid-FIGHT -> all outputs at reset values before the next clk edge; fsm_state=0 after release.
REQ-036 Verification SHALL cover: start=1 with COUNT_TICKS=3 -> round_rst pulse, fsm_state=2, play_en rises one clock after the 3rd tick.
REQ-037 Verification SHALL cover: both requests on 4 consecutive ticks -> grants alternate 1,2,1,2; a single act_req2 -> grant2 with the pointer unchanged.
REQ-038 Verification SHALL cover: lives2=0 at a tick twice (ROUNDS_TO_WIN=2) -> wins1=1 then 2, round_num=2, winner=01, fsm_state=5.
REQ-039 Verification SHALL cover: lives1=lives2=0 at the same tick -> wins unchanged, round_num incremented, round replayed.
REQ-040 Verification SHALL cover, with SUDDEN_DEATH_EN and ROUND_TICKS=5: lives1=3, lives2=1 held -> after the 5th tick, wins1 increments.
